gpdin: RTL

- Memory-mapped general-purpose data input port; the input-direction counterpart of the gpdout register.
- Samples 32 external edge pins (big endian) through a 2-flop synchronizer and presents them on the CPU data bus (little endian, byte-reversed).
- Records sticky rise and fall flags per pin, cleared by write-1-to-clear (W1C).
- Raises a maskable level interrupt.

---
 rtl/gpdin.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gpdin.sv
// Memory-mapped general-purpose data input port: synchronized pins, sticky rise/fall flags (W1C), maskable irq.
// Optional debounce filter on the synchronized pins is enabled by defining GPDIN_DEBOUNCE_EN.
module gpdin #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  input  logic [31:0] dinFromEdge,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned AW = $clog2(SYNC_STAGES + DB_CYCLES + 3);
`ifdef GPDIN_DEBOUNCE_EN
  // Hold flags off until the debounced path has settled, so pins high in reset raise no flag.
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + DB_CYCLES + 2;
`else
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
`endif

  localparam logic [1:0] A_DATA  = 2'd0;
  localparam logic [1:0] A_RISE  = 2'd1;
  localparam logic [1:0] A_FALL  = 2'd2;
  localparam logic [1:0] A_IRQEN = 2'd3;

  // Byte reversal between pin order and bus order; it is its own inverse.
  function automatic logic [W-1:0] sw(input logic [W-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync;
  logic [W-1:0] stable;
  logic [W-1:0] prev_q;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;
  logic [W-1:0] irqen_q, irqen_d;
  logic [W-1:0] wmask, wdata, rd_mux;
  logic [AW-1:0] arm_cnt;
  logic          armed;
  logic          wr, rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= dinFromEdge;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPDIN_DEBOUNCE_EN
  logic [W-1:0]  stable_q, sync_d;
  logic [CW-1:0] db_cnt;

  // One shared stability counter: any change on any synchronized pin restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      sync_d   <= '0;
      db_cnt   <= '0;
    end else begin
      sync_d <= sync;
      if (sync != sync_d) begin
        db_cnt <= '0;
      end else begin
        if (db_cnt != CW'(DB_CYCLES)) db_cnt <= db_cnt + CW'(1);
        if (db_cnt == CW'(DB_CYCLES - 1)) stable_q <= sync;
      end
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + AW'(1);
      armed   <= (arm_cnt == AW'(ARM_CYCLES - 1));
    end
  end

  assign wr    = en & (|wen);
  assign rd    = en & ~(|wen);
  assign wmask = {{8{wen[0]}}, {8{wen[1]}}, {8{wen[2]}}, {8{wen[3]}}};
  assign wdata = sw(din) & wmask;

  // Next flag/enable state; a new edge wins over a same-cycle W1C.
  always_comb begin
    rise_d  = rise_q;
    fall_d  = fall_q;
    irqen_d = irqen_q;
    if (wr && addr == A_RISE) rise_d = rise_d & ~wdata;
    if (wr && addr == A_FALL) fall_d = fall_d & ~wdata;
    if (wr && addr == A_IRQEN) irqen_d = (irqen_q & ~wmask) | wdata;
    if (armed) begin
      rise_d = rise_d | (stable & ~prev_q);
      fall_d = fall_d | (~stable & prev_q);
    end
  end

  always_comb begin
    rd_mux = sw(stable);
    case (addr)
      A_DATA:  rd_mux = sw(stable);
      A_RISE:  rd_mux = sw(rise_q);
      A_FALL:  rd_mux = sw(fall_q);
      A_IRQEN: rd_mux = sw(irqen_q);
      default: rd_mux = sw(stable);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      irqen_q <= '0;
      rdata   <= '0;
      irq     <= 1'b0;
    end else begin
      prev_q  <= stable;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      irqen_q <= irqen_d;
      irq     <= |((rise_q | fall_q) & irqen_q);
      if (rd) rdata <= rd_mux;
    end
  end

endmodule
